// File: rtl/graf_pkg.sv
// Shared framebuffer geometry and types for the graphics plotting path.
package graf_pkg;

   localparam int unsigned SCREEN_W       = 640;
   localparam int unsigned SCREEN_H       = 480;
   localparam int unsigned WORDS_PER_LINE = 40;
   localparam int unsigned FB_WORDS       = 19200;
   localparam int unsigned CAM_NO_BLOB    = 1023;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_GNT,
      ST_READ,
      ST_READ_WAIT,
      ST_WRITE,
      ST_WRITE_WAIT
   } plot_state_t;

   // One pixel update: framebuffer word, bit within the word, and clear/set.
   typedef struct packed {
      logic [17:0] address;
      logic [3:0]  bit_index;
      logic        erase;
   } plot_req_t;

endpackage

// File: rtl/cam_to_fb_addr.sv
// Camera coordinate filter and scaling into a framebuffer word address and bit index.
module cam_to_fb_addr #(
   parameter int unsigned CAM_W          = 1024,
   parameter int unsigned CAM_H          = 768,
   parameter int unsigned WORDS_PER_LINE = 40
) (
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   output logic        valid,
   output logic [17:0] address,
   output logic [3:0]  bit_index
);

   logic [12:0] x_prod;
   logic [12:0] y_prod;
   logic [9:0]  sx;
   logic [9:0]  sy;

   always_comb begin
      // x*5 as x + 4x keeps the product inside 13 bits
      x_prod    = {3'b000, x} + {1'b0, x, 2'b00};
      y_prod    = {3'b000, y} + {1'b0, y, 2'b00};
      sx        = x_prod[12:3];
      sy        = y_prod[12:3];
      address   = 18'(18'(sy) * 18'(WORDS_PER_LINE)) + 18'(sx[9:4]);
      bit_index = sx[3:0];
      valid     = (32'(x) != CAM_W - 1) && (32'(y) < CAM_H);
   end

endmodule

// File: rtl/pixel_plotter.sv
// Plots filtered camera points into the 1-bit framebuffer via a granted
// read-modify-write on the shared SRAM port.
module pixel_plotter
   import graf_pkg::*;
#(
   parameter int unsigned CAM_W          = 1024,
   parameter int unsigned CAM_H          = 768,
   parameter int unsigned WORDS_PER_LINE = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        point_valid,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        erase,
   output logic        req,
   input  logic        gnt,
   output logic [17:0] address,
   output logic [15:0] data_write,
   input  logic [15:0] data_read,
   output logic        read,
   output logic        write,
   input  logic        ready,
   output logic        busy,
   output logic [7:0]  drop_count
);

   plot_state_t state, state_next;
   plot_req_t   point, pend, work, last;
   logic        point_ok, pend_full, last_valid;
   logic        dup, accept, consume, read_done, write_done;
   logic [15:0] mask;

   cam_to_fb_addr #(
      .CAM_W          (CAM_W),
      .CAM_H          (CAM_H),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_addr (
      .x         (x),
      .y         (y),
      .valid     (point_ok),
      .address   (point.address),
      .bit_index (point.bit_index)
   );

   always_comb begin
      point.erase = erase;
      dup         = last_valid && (point == last);
      accept      = point_valid && point_ok && !dup;
      consume     = (state == ST_WAIT_GNT) && gnt;
      read_done   = ((state == ST_READ) || (state == ST_READ_WAIT)) && ready;
      write_done  = ((state == ST_WRITE) || (state == ST_WRITE_WAIT)) && ready;
      mask        = 16'b1 << work.bit_index;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // A completion pulse can arrive in the strobe's first cycle, so the
   // strobe states exit on ready directly as well as via their wait states.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:       if (pend_full) state_next = ST_WAIT_GNT;
         ST_WAIT_GNT:   if (gnt)       state_next = ST_READ;
         ST_READ:       state_next = ready ? ST_WRITE : ST_READ_WAIT;
         ST_READ_WAIT:  if (ready)     state_next = ST_WRITE;
         ST_WRITE:      state_next = ready ? ST_IDLE : ST_WRITE_WAIT;
         ST_WRITE_WAIT: if (ready)     state_next = ST_IDLE;
         default:       state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != ST_IDLE);
      req   = busy;
      read  = (state == ST_READ) || (state == ST_READ_WAIT);
      write = (state == ST_WRITE) || (state == ST_WRITE_WAIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend       <= '0;
         pend_full  <= 1'b0;
         work       <= '0;
         last       <= '0;
         last_valid <= 1'b0;
         data_write <= '0;
         drop_count <= '0;
      end else begin
         // A fill coinciding with the hand-off to the working register is not a drop
         if (accept) begin
            pend      <= point;
            pend_full <= 1'b1;
            if (pend_full && !consume && (drop_count != '1))
               drop_count <= drop_count + 8'd1;
         end else if (consume) begin
            pend_full <= 1'b0;
         end
         if (consume) work <= pend;
         if (read_done)
            data_write <= work.erase ? (data_read & ~mask) : (data_read | mask);
         if (write_done) begin
            last       <= work;
            last_valid <= 1'b1;
         end
      end
   end

   assign address = work.address;

endmodule

// File: tb/tb_pixel_plotter.sv
// Randomized bench for pixel_plotter with an SRAM responder and a framebuffer reference model.
module tb_pixel_plotter;

   logic        clk = 1'b0;
   logic        reset, point_valid, erase, gnt, ready;
   logic [9:0]  x, y;
   logic        req, read, write, busy;
   logic [17:0] address;
   logic [15:0] data_write, data_read;
   logic [7:0]  drop_count;

   always #5 clk = ~clk;

   pixel_plotter #(
      .CAM_W          (1024),
      .CAM_H          (768),
      .WORDS_PER_LINE (40)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .point_valid (point_valid),
      .x           (x),
      .y           (y),
      .erase       (erase),
      .req         (req),
      .gnt         (gnt),
      .address     (address),
      .data_write  (data_write),
      .data_read   (data_read),
      .read        (read),
      .write       (write),
      .ready       (ready),
      .busy        (busy),
      .drop_count  (drop_count)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [15:0] mem     [19200];
   logic [15:0] ref_mem [19200];

   int          n_writes = 0, n_reads = 0, bad_addr = 0, bus_viol = 0;
   logic [17:0] last_wr_addr = '0, last_rd_addr = '0;
   logic [15:0] last_wr_data = '0;
   bit          stall = 0;
   int          lat_max = 0, cnt = 0, lat = 0;

   int  exp_writes = 0;
   bit  ref_last_valid = 0;
   int  ref_last_addr = 0, ref_last_bit = 0;
   bit  ref_last_erase = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // SRAM responder: one-cycle ready pulse a random number of cycles after each strobe
   initial begin
      ready     = 1'b0;
      data_read = '0;
      forever begin
         @(posedge clk);
         #1;
         if (ready) begin
            ready = 1'b0;
            cnt   = 0;
         end else if (!(read || write)) begin
            cnt = 0;
         end else if (!stall) begin
            if (cnt >= lat) begin
               ready = 1'b1;
               cnt   = 0;
               lat   = $urandom_range(0, lat_max);
               if (address >= 18'd19200) bad_addr++;
               else if (read) begin
                  data_read    = mem[address];
                  last_rd_addr = address;
                  n_reads++;
               end else begin
                  mem[address] = data_write;
                  last_wr_addr = address;
                  last_wr_data = data_write;
                  n_writes++;
               end
            end else cnt++;
         end
      end
   end

   logic        prev_rd = 1'b0, prev_wr = 1'b0;
   logic [17:0] prev_addr = '0;
   logic [15:0] prev_data = '0;
   always @(negedge clk) begin
      if (read && prev_rd && address != prev_addr) bus_viol++;
      if (write && prev_wr && (address != prev_addr || data_write != prev_data)) bus_viol++;
      if ((read || write) && !busy) bus_viol++;
      prev_rd   = read;
      prev_wr   = write;
      prev_addr = address;
      prev_data = data_write;
   end

   task automatic ref_point(input int px, input int py, output bit ok, output int a, output int b);
      int sx, sy;
      ok = (px != 1023) && (py < 768);
      sx = (px * 5) / 8;
      sy = (py * 5) / 8;
      a  = sy * 40 + sx / 16;
      b  = sx % 16;
   endtask

   task automatic ref_apply(input int px, input int py, input bit pe);
      bit ok;
      int a, b;
      ref_point(px, py, ok, a, b);
      if (!ok) return;
      if (ref_last_valid && a == ref_last_addr && b == ref_last_bit && pe == ref_last_erase) return;
      ref_mem[a][b]  = !pe;
      exp_writes++;
      ref_last_valid = 1;
      ref_last_addr  = a;
      ref_last_bit   = b;
      ref_last_erase = pe;
   endtask

   task automatic send(input int px, input int py, input bit pe);
      @(negedge clk);
      x           = px[9:0];
      y           = py[9:0];
      erase       = pe;
      point_valid = 1'b1;
      @(negedge clk);
      point_valid = 1'b0;
   endtask

   task automatic wait_done();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 200 && busy; i++) begin
         @(posedge clk);
         #1;
      end
      check("done_timeout", 32'(busy), 0);
   endtask

   task automatic count_req(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (req) seen++;
      end
   endtask

   initial begin
      int  seen, a, b, w0, px, py, r;
      bit  ok, pe;

      reset = 1'b1; point_valid = 1'b0; x = '0; y = '0; erase = 1'b0; gnt = 1'b0;
      for (int i = 0; i < 19200; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end

      repeat (3) @(posedge clk);
      #1;
      check("rst_req", 32'(req), 0);
      check("rst_read", 32'(read), 0);
      check("rst_write", 32'(write), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_address", 32'(address), 0);
      check("rst_data_write", 32'(data_write), 0);
      check("rst_drop", 32'(drop_count), 0);
      @(negedge clk);
      reset = 1'b0;
      gnt   = 1'b1;

      // origin point with capture latency
      mem[0] = 16'h0000; ref_mem[0] = 16'h0000;
      @(negedge clk);
      x = '0; y = '0; erase = 1'b0; point_valid = 1'b1;
      @(posedge clk); #1;
      check("lat_req_edge0", 32'(req), 0);
      @(negedge clk);
      point_valid = 1'b0;
      @(posedge clk); #1;
      check("lat_req_edge1", 32'(req), 1);
      ref_apply(0, 0, 0);
      wait_done();
      check("origin_reads", 32'(n_reads), 1);
      check("origin_rd_addr", 32'(last_rd_addr), 0);
      check("origin_wr_addr", 32'(last_wr_addr), 0);
      check("origin_wr_data", 32'(last_wr_data), 32'h0001);
      check("origin_writes", 32'(n_writes), 32'(exp_writes));

      // far corner, erase
      mem[19199] = 16'hFFFF; ref_mem[19199] = 16'hFFFF;
      send(1022, 767, 1);
      ref_apply(1022, 767, 1);
      wait_done();
      check("corner_wr_addr", 32'(last_wr_addr), 19199);
      check("corner_wr_data", 32'(last_wr_data), 32'hBFFF);
      check("corner_writes", 32'(n_writes), 32'(exp_writes));

      // invalid points never request the port
      send(1023, $urandom_range(0, 1023), 0);
      send(500, 800, 0);
      count_req(20, seen);
      check("invalid_req", 32'(seen), 0);
      check("invalid_drop", 32'(drop_count), 0);
      check("invalid_writes", 32'(n_writes), 32'(exp_writes));

      // overwrite while the port is withheld
      @(negedge clk);
      gnt = 1'b0;
      send(100, 100, 0);
      send(200, 300, 0);
      send(640, 400, 0);
      repeat (3) @(posedge clk);
      #1;
      check("ovw_drop", 32'(drop_count), 2);
      check("ovw_no_write", 32'(n_writes), 32'(exp_writes));
      @(negedge clk);
      gnt = 1'b1;
      ref_apply(640, 400, 0);
      wait_done();
      ref_point(640, 400, ok, a, b);
      check("ovw_writes", 32'(n_writes), 32'(exp_writes));
      check("ovw_wr_addr", 32'(last_wr_addr), 32'(a));
      check("ovw_mem", 32'(mem[a]), 32'(ref_mem[a]));

      // dedup: repeat is ignored, flipped erase is not
      send(640, 400, 0);
      ref_apply(640, 400, 0);
      wait_done();
      check("dedup_same", 32'(n_writes), 32'(exp_writes));
      send(640, 400, 1);
      ref_apply(640, 400, 1);
      wait_done();
      check("dedup_flip", 32'(n_writes), 32'(exp_writes));
      check("dedup_mem", 32'(mem[a]), 32'(ref_mem[a]));
      check("dedup_drop", 32'(drop_count), 2);

      // reset during READ_WAIT
      stall = 1;
      send(300, 200, 1);
      seen = 0;
      for (int i = 0; i < 50 && !read; i++) begin
         @(posedge clk);
         #1;
      end
      check("rst_mid_read_seen", 32'(read), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_read", 32'(read), 0);
      check("rst_mid_req", 32'(req), 0);
      check("rst_mid_write", 32'(write), 0);
      check("rst_mid_drop", 32'(drop_count), 0);
      @(negedge clk);
      reset = 1'b0;
      stall = 0;
      ref_last_valid = 0;
      w0 = n_writes;
      count_req(20, seen);
      check("rst_mid_pend_empty", 32'(seen), 0);
      check("rst_mid_no_write", 32'(n_writes), 32'(w0));
      ref_point(300, 200, ok, a, b);
      check("rst_mid_mem", 32'(mem[a]), 32'(ref_mem[a]));
      send(640, 400, 1);
      ref_apply(640, 400, 1);
      wait_done();
      check("rst_last_cleared", 32'(n_writes), 32'(exp_writes));

      // randomized points with random completion latency
      lat_max = 3;
      px = 0; py = 0; pe = 0;
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 7);
         if (r != 2) begin
            px = $urandom_range(0, 1022);
            py = $urandom_range(0, 767);
            pe = 1'($urandom);
            if (r == 0) px = 1023;
            if (r == 1) py = $urandom_range(768, 1023);
         end
         send(px, py, pe);
         ref_apply(px, py, pe);
         wait_done();
         check("rnd_writes", 32'(n_writes), 32'(exp_writes));
         ref_point(px, py, ok, a, b);
         if (ok) check("rnd_mem", 32'(mem[a]), 32'(ref_mem[a]));
      end

      check("bus_violations", 32'(bus_viol), 0);
      check("bad_address", 32'(bad_addr), 0);
      check("final_drop", 32'(drop_count), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pixel_plotter.md
# pixel_plotter

Plots camera-tracked points into the 640x480 1-bit SRAM framebuffer. Accepts raw IR-camera coordinates, scales them to screen space, and performs a read-modify-write of the affected 16-bit word through the shared `sram` controller port. Sits upstream of the SRAM controller, beside the line-buffer fetch state machine. It borrows the memory port only through a req/gnt handshake with that fetch logic.

## Interface
Parameters:
- `CAM_W`, 1024: camera x range; value `CAM_W-1` means "no blob".
- `CAM_H`, 768: camera y range; y >= `CAM_H` means invalid.
- `WORDS_PER_LINE`, 40: 16-pixel words per screen line.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `point_valid`  in  1  one-cycle pulse; `x`/`y` are valid.
- `x`  in  10  camera x.
- `y`  in  10  camera y.
- `erase`  in  1  sampled with `point_valid`; 1 clears the pixel, 0 sets it.
- `req`  out  1  request for the SRAM port.
- `gnt`  in  1  port granted; held by the owner until `req` falls.
- `address`  out  18  SRAM word address.
- `data_write`  out  16  write data.
- `data_read`  in  16  read data; valid in the cycle `ready`=1.
- `read`  out  1  read strobe; held until `ready`.
- `write`  out  1  write strobe; held until `ready`.
- `ready`  in  1  one-cycle completion pulse from `sram`.
- `busy`  out  1  state is not IDLE.
- `drop_count`  out  8  points overwritten before service; saturates at 255.

## Operation
- **Input filter.** Discard the point if x == 1023 or y >= 768. A discarded point touches no state.
- **Scaling.** Compute sx = (x*5)>>3 and sy = (y*5)>>3, using 13-bit intermediate products. Results: sx is 0..638, sy is 0..479.
- **Addressing.** address = sy*40 + sx[9:4], maximum 19199, zero-extended to 18 bits. Bit index = sx[3:0].
- **Pending register.** One entry: address, bit, erase.
  - An accepted point while the entry is empty fills it.
  - An accepted point while the entry is full overwrites it (latest wins) and increments `drop_count`.
  - An accepted point in the same cycle the FSM consumes the entry fills the entry and is not counted as a drop.
- **Dedup.** Drop a point when its address, bit and erase all equal the last completed write. This is not counted as a drop. `reset` invalidates the last-write record.
- **FSM states:**
  - IDLE: when pending is full, assert `req` and go to WAIT_GNT.
  - WAIT_GNT: when `gnt`=1, move pending into the working register, clear pending, and go to READ.
  - READ: drive `address`, set `read`=1.
  - READ_WAIT: on `ready`, set `read`=0 and latch `data_read`. Go to WRITE.
  - WRITE: drive `data_write` = latched word with the target bit set or cleared. Set `write`=1.
  - WRITE_WAIT: on `ready`, set `write`=0 and `req`=0, record the last write, and go to IDLE.
- **Grant handling.** `gnt` is ignored outside WAIT_GNT. Once granted, the transaction always completes. The owner must not deassert `gnt` while `req`=1.

## Timing
- **Reset values.** `req`, `read`, `write`, `busy` = 0. `address`, `data_write` = 0. `drop_count` = 0. Pending empty, FSM in IDLE.
- **Reset mid-transaction.** Strobes and `req` fall in the cycle after `reset` is sampled. Any partial RMW is abandoned and the SRAM word is left unchanged.
- **Capture latency.** The point is registered at edge 0 (scaling is combinational into the pending register). `req` is high after edge 1.
- **Minimum latency.** With `gnt` already high and `ready` arriving k cycles after each strobe, the point takes 5 + 2k cycles from `point_valid` to the `write` strobe falling.
- **Bus stability.** `address` and `data_write` stay stable for as long as the respective strobe is high.
- **Idle bus.** Strobes are never high in IDLE or WAIT_GNT.

## Structure
- Shared package `graf_pkg` holds:
  - `SCREEN_W`=640, `SCREEN_H`=480, `WORDS_PER_LINE`=40, `FB_WORDS`=19200.
  - `CAM_NO_BLOB`=1023.
  - The FSM state enum.
- One sub-module, `cam_to_fb_addr`: combinational filter, scaling and address/bit computation. It is also reusable by a future cursor overlay.

## Test plan
- **Origin point.** x=0, y=0, erase=0, `gnt` tied 1, `data_read`=16'h0000. Expect a read of address 0, then a write of 16'h0001 to address 0.
- **Far corner.** x=1022, y=767. Expect sx=638, sy=479, address 19199, bit 14. With `data_read`=16'hFFFF and erase=1, expect a write of 16'hBFFF.
- **Invalid points.** x=1023 any y, and y=800. Expect `req` to stay 0 for 20 cycles and `drop_count`=0.
- **Overwrite while busy.** Hold `gnt`=0 and send three valid points. Expect `drop_count`=2; after `gnt`=1, only the third point is written.
- **Dedup.** Send the same point twice, the second after completion. Expect one RMW only. The same point with erase flipped must trigger a second RMW.
- **Reset mid-operation.** Assert `reset` during READ_WAIT. Expect `read`/`req` low the next cycle, no write issued, and the pending register empty.
